matrix_mult_core: RTL and testbench
===================================

Name: matrix_mult_core

Overview:
- Upstream producer for the matrix write-back stage.
- Computes the 2x2 product C = A x B of 8-bit unsigned matrices using a single time-shared 8x8 multiplier and a 17-bit accumulator.
- Presents the packed 32-bit result with a one-cycle `done`/`is_matrix_mult` pulse that launches the four-cycle register write-back.
- Holds C stable until the next operation completes.

Parameters:
- SATURATE, 0, 0 = each element is its sum mod 256; 1 = each element clamps to 8'hFF when the sum exceeds 255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 resets the block.
- start  input  1  request to begin a multiply; qualified per the acceptance rule below.
- A  input  32  operand A, row-major: [7:0]=a00, [15:8]=a01, [23:16]=a10, [31:24]=a11.
- B  input  32  operand B, same packing.
- wb_busy  input  1  write-back stage in progress (its matrix_write_in_progress).
- C  output  32  result, same packing: [7:0]=c00, [15:8]=c01, [23:16]=c10, [31:24]=c11.
- done  output  1  one-cycle completion pulse.
- is_matrix_mult  output  1  one-cycle write-back launch pulse, identical timing to done.
- busy  output  1  high while an operation is in flight (state != IDLE).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, cnt=0, accumulator=0, shadow result R=0.
  - C=0, done=0, is_matrix_mult=0, busy=0.
  - Applies mid-operation: the operation is aborted and no done pulse is produced.
- States: IDLE, MAC, FIN.
- Acceptance:
  - start is accepted at edge E0 only if state==IDLE && !wb_busy && !done.
  - On acceptance, A and B are latched into internal operand registers, cnt<=0, state<=MAC.
  - start under any other condition is ignored; it is not queued.
- MAC (edges E0+1..E0+8, cnt 0..7):
  - cnt[2:1] selects element (0=c00, 1=c01, 2=c10, 3=c11) as (i,j); cnt[0] selects term k.
  - Each term is the product a_ik*b_kj.
  - k=0: acc <= product.
  - k=1: the final sum acc+product is reduced per SATURATE and written into R's byte for the element.
  - cnt increments by 1 each cycle; at cnt==7, state<=FIN.
- FIN (edge E0+9):
  - C<=R, done<=1, is_matrix_mult<=1, state<=IDLE.
- Pulses and latency:
  - done and is_matrix_mult are high for exactly the one cycle after E0+9; they deassert at the next edge.
  - Latency from accepting edge to pulse: 9 cycles.
  - busy is high from after E0 through the cycle after E0+8, and low during the pulse cycle.
- Width: the product is 16 bits; the sum is 17 bits (max 130050, no overflow).
  - SATURATE=0: the element takes sum[7:0].
  - SATURATE=1: the element takes 8'hFF if sum>255.
- C stability:
  - C changes only in FIN; A and B may change freely after acceptance.
  - The write-back stage samples C over its 4 write cycles. The `!done` and `!wb_busy` gating prevents a new start in the pulse cycle, before wb_busy has risen.
  - Any later operation updates C at least 9 cycles after acceptance.
- Simultaneous events: reset has priority over start and over all state transitions.

Test Plan:
- Basic product: reset low for 2 cycles, then high; A=0x04030201, B=0x08070605, start for 1 cycle -> exactly 9 cycles later, done=is_matrix_mult=1 for one cycle with C=0x322B1613; busy low afterwards.
- Overflow, both modes: A=B=0xC8C8C8C8.
  - SATURATE=0 -> C=0x80808080.
  - SATURATE=1 -> C=0xFFFFFFFF.
- Start while busy: start held high for 5 cycles from acceptance -> exactly one done pulse, and C reflects the first latched operands.
- Write-back gating: attach the write-back stage, then issue start on every cycle -> no start is accepted during the done cycle or while wb_busy=1. C holds each value through all 4 write-back cycles, with destreg 0..3 receiving C bytes [7:0]..[31:24].
- Reset mid-operation: assert reset low at cnt=4 -> next cycle busy=0, C=0, no done pulse. A new start with identity A=0x01000001 and B=0x0D0C0B0A -> C=0x0D0C0B0A.
- Operand change after acceptance: change A and B on the cycle after start -> result uses the originally latched values.

Source files
------------

// File: rtl/matrix_mult_core.sv
// 2x2 unsigned 8-bit matrix product C = A x B using one time-shared 8x8 multiplier.
// The result is held stable in C and announced with a one-cycle done/is_matrix_mult pulse.
module matrix_mult_core #(
    parameter bit SATURATE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        wb_busy,
    output logic [31:0] C,
    output logic        done,
    output logic        is_matrix_mult,
    output logic        busy
);

    localparam int unsigned EW = 8;
    localparam int unsigned MW = 32;
    localparam int unsigned PW = 16;
    localparam int unsigned SW = 17;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] a_q, a_d;
    logic [MW-1:0] b_q, b_d;
    logic [MW-1:0] r_q, r_d;
    logic [MW-1:0] c_d;
    logic [SW-1:0] acc_q, acc_d;
    logic          done_d;
    logic          busy_d;

    logic [1:0]    a_sel;
    logic [1:0]    b_sel;
    logic [1:0]    e_sel;
    logic [EW-1:0] a_op;
    logic [EW-1:0] b_op;
    logic [PW-1:0] prod;
    logic [SW-1:0] sum;
    logic [EW-1:0] elem;

    // cnt = {i, j, k}: a_ik lives at byte {i,k}, b_kj at byte {k,j}, c_ij at byte {i,j}
    always_comb begin
        a_sel = {cnt_q[2], cnt_q[0]};
        b_sel = {cnt_q[0], cnt_q[1]};
        e_sel = cnt_q[2:1];
        a_op  = a_q[{a_sel, 3'b000} +: EW];
        b_op  = b_q[{b_sel, 3'b000} +: EW];
        prod  = PW'(a_op) * PW'(b_op);
        sum   = acc_q + SW'(prod);
        if (SATURATE && (sum > SW'(255))) begin
            elem = '1;
        end else begin
            elem = sum[EW-1:0];
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        r_d     = r_q;
        c_d     = C;
        done_d  = 1'b0;
        busy_d  = busy;

        case (state_q)
            IDLE: begin
                // done blocks the pulse cycle, before the write-back stage raises wb_busy
                if (start && !wb_busy && !done) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (!cnt_q[0]) begin
                    acc_d = SW'(prod);
                end else begin
                    r_d[{e_sel, 3'b000} +: EW] = elem;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(7)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                c_d     = r_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            acc_q          <= '0;
            r_q            <= '0;
            C              <= '0;
            done           <= 1'b0;
            is_matrix_mult <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            acc_q          <= acc_d;
            r_q            <= r_d;
            C              <= c_d;
            done           <= done_d;
            is_matrix_mult <= done_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_matrix_mult_core.sv
// Bench for matrix_mult_core: both SATURATE variants against a transaction-level model,
// with a small write-back stage model driving wb_busy and capturing C.
module tb_matrix_mult_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        wb_busy;
    logic [31:0] C0, C1;
    logic        done0, done1, imm0, imm1, busy0, busy1;

    int errors = 0;
    int checks = 0;

    matrix_mult_core #(.SATURATE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .wb_busy(wb_busy),
        .C(C0), .done(done0), .is_matrix_mult(imm0), .busy(busy0)
    );

    matrix_mult_core #(.SATURATE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .wb_busy(wb_busy),
        .C(C1), .done(done1), .is_matrix_mult(imm1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int elem_of(input logic [31:0] m, input int r, input int c);
        return int'((m >> (8 * (2 * r + c))) & 32'hFF);
    endfunction

    // plain matrix product, returning both wrap and clamp interpretations
    task automatic ref_mult(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] wrap, output logic [31:0] sat);
        int s;
        wrap = '0;
        sat  = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = elem_of(a, i, 0) * elem_of(b, 0, j) + elem_of(a, i, 1) * elem_of(b, 1, j);
                wrap[8 * (2 * i + j) +: 8] = 8'(s % 256);
                sat[8 * (2 * i + j) +: 8]  = (s > 255) ? 8'hFF : 8'(s);
            end
        end
    endtask

    // transaction model: an accepted op completes 9 edges later
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic        m_acc;
    logic [31:0] m_c0 = '0, m_c1 = '0, m_p0 = '0, m_p1 = '0;
    bit          started = 0;

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_c0   = '0;
            m_c1   = '0;
        end else begin
            m_acc  = start && (m_left == 0) && !wb_busy && !m_done;
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_c0   = m_p0;
                    m_c1   = m_p1;
                end
            end else if (m_acc) begin
                ref_mult(A, B, m_p0, m_p1);
                m_left = 9;
            end
        end
        started = 1;
    end

    // write-back stage: 4 cycles after the launch pulse, one C byte per cycle
    int         wb_cnt = 0;
    logic [7:0] destreg [4];
    logic       wb_fin = 1'b0;

    always @(posedge clk) begin
        wb_fin <= 1'b0;
        if (!reset) begin
            wb_cnt  <= 0;
            wb_busy <= 1'b0;
        end else if (wb_cnt > 0) begin
            destreg[4 - wb_cnt] <= C0[8 * (4 - wb_cnt) +: 8];
            wb_cnt  <= wb_cnt - 1;
            wb_busy <= (wb_cnt > 1);
            if (wb_cnt == 1) wb_fin <= 1'b1;
        end else if (imm0) begin
            wb_cnt  <= 4;
            wb_busy <= 1'b1;
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("done0", 32'(done0), 32'(m_done));
            check("imm0", 32'(imm0), 32'(m_done));
            check("busy0", 32'(busy0), 32'(m_left > 0));
            check("C0", C0, m_c0);
            check("done1", 32'(done1), 32'(m_done));
            check("imm1", 32'(imm1), 32'(m_done));
            check("busy1", 32'(busy1), 32'(m_left > 0));
            check("C1", C1, m_c1);
            if (wb_fin) begin
                for (int i = 0; i < 4; i++) begin
                    check("destreg", 32'(destreg[i]), 32'(m_c0[8 * i +: 8]));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || wb_busy || done0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 32'(n), 32'(0));
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e0, input logic [31:0] e1, input bit chg);
        int lat;
        wait_idle();
        A = a;
        B = b;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (chg) begin
                A = $urandom;
                B = $urandom;
            end
        end while (!done0 && lat < 30);
        check("latency", 32'(lat - 1), 32'(9));
        check("C0_lit", C0, e0);
        check("C1_lit", C1, e1);
        check("model0_lit", m_c0, e0);
        check("model1_lit", m_c1, e1);
    endtask

    int pulses;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        check("rst_C", C0, 32'h0);
        check("rst_done", 32'(done0), 32'(0));
        check("rst_busy", 32'(busy0), 32'(0));
        reset = 1'b1;

        run_op(32'h04030201, 32'h08070605, 32'h322B1613, 32'h322B1613, 0);
        run_op(32'hC8C8C8C8, 32'hC8C8C8C8, 32'h80808080, 32'hFFFFFFFF, 0);
        run_op(32'h04030201, 32'h08070605, 32'h322B1613, 32'h322B1613, 1);

        // start held for 5 cycles while operands keep changing
        wait_idle();
        A = 32'h01000001;
        B = 32'h44332211;
        start = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c < 4) begin
                A = $urandom;
                B = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done0) pulses++;
        end
        check("hold_pulses", 32'(pulses), 32'(1));
        check("hold_C0", C0, 32'h44332211);

        // reset while cnt==4
        wait_idle();
        A = 32'hFFFFFFFF;
        B = 32'h12345678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy0), 32'(0));
        check("abort_C", C0, 32'h0);
        reset = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done0) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'(0));
        run_op(32'h01000001, 32'h0D0C0B0A, 32'h0D0C0B0A, 32'h0D0C0B0A, 0);

        // start on every cycle: one acceptance per 15 cycles with write-back attached
        wait_idle();
        start = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            if (done0) pulses++;
        end
        start = 1'b0;
        check("stream_pulses", 32'(pulses), 32'(5));

        // randomized traffic with occasional resets
        repeat (400) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            A = $urandom;
            B = $urandom;
            reset = ($urandom_range(0, 80) != 0);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
